// File: rtl/uart_defs_pkg.sv
// Shared encodings for the UART MMIO port: TX/RX FSM states and the
// bit positions of the status/data word returned on CPU loads.
package uart_defs;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam int RX_BYTE_LSB  = 0;
  localparam int TX_FULL_BIT  = 8;
  localparam int RX_VALID_BIT = 9;
  localparam int OVERRUN_BIT  = 10;
  localparam int TX_BUSY_BIT  = 11;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; head is readable
// combinationally. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int TX_DEPTH = 4,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [TX_DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign pop_dat = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + PTR_ONE;
      if (pop && !empty) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_mmio_port.sv
// Memory-mapped 8N1 UART: CPU stores fill a TX FIFO drained by the TX FSM,
// the RX FSM fills a one-byte holding register, loads return status/data.
module uart_mmio_port
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0] fifo_head;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:8];
  assign fifo_push    = sel & wr & ~fifo_full;

  uart_tx_fifo #(.TX_DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (wdata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_head;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the next state so the output comes straight from a flop.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic            rx_commit, rd_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_commit  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Mid-bit check of the start bit; a high line here was only a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_commit  = rx_s_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A load in the commit cycle consumes the old flags, so overrun is not raised.
  assign rd_clr     = sel & rd;
  assign rx_valid_d = rx_commit | (rx_valid_q & ~rd_clr);
  assign overrun_d  = ~rd_clr & (overrun_q | (rx_commit & rx_valid_q));
  assign rx_byte_d  = rx_commit ? rx_shift_q : rx_byte_q;

  always_comb begin
    rdata                       = '0;
    rdata[RX_BYTE_LSB +: 8]     = rx_byte_q;
    rdata[TX_FULL_BIT]          = fifo_full;
    rdata[RX_VALID_BIT]         = rx_valid_q;
    rdata[OVERRUN_BIT]          = overrun_q;
    rdata[TX_BUSY_BIT]          = (tx_state_q != TX_IDLE) | ~fifo_empty;
  end

endmodule

// File: tb/tb_uart_mmio_port.sv
// Directed bench for uart_mmio_port: a frame-schedule model predicts tx and
// rdata every cycle; literal per-cycle expectations pin the model itself.
module tb_uart_mmio_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, wr = 1'b0, rd = 1'b0, rx = 1'b1;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  uart_mmio_port #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .wr    (wr),
    .rd    (rd),
    .wdata (wdata),
    .rdata (rdata),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: every accepted byte becomes a frame with a push cycle and a start cycle.
  int         fr_push[$];
  int         fr_start[$];
  logic [7:0] fr_byte[$];
  int         pend_cyc[$];
  logic [7:0] pend_byte[$];
  logic [7:0] m_byte = '0;
  logic       m_vld = 1'b0, m_ovr = 1'b0;

  function automatic int fifo_count(input int n);
    int c = 0;
    foreach (fr_push[i]) if (fr_push[i] + 1 <= n && n <= fr_start[i] - 1) c++;
    return c;
  endfunction

  function automatic logic busy_at(input int n);
    foreach (fr_push[i]) if (fr_push[i] + 1 <= n && n <= fr_start[i] + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic tx_at(input int n);
    int k;
    logic [7:0] b;
    foreach (fr_start[i]) begin
      if (fr_start[i] <= n && n < fr_start[i] + FRAME) begin
        k = (n - fr_start[i]) / CPB;
        b = fr_byte[i];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] rdata_at(input int n);
    return {20'b0, busy_at(n), m_ovr, m_vld, (fifo_count(n) == DEPTH), m_byte};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_push.delete(); fr_start.delete(); fr_byte.delete();
      pend_cyc.delete(); pend_byte.delete();
      m_byte = '0; m_vld = 1'b0; m_ovr = 1'b0;
    end else begin : model_step
      int         s;
      logic       commit, rd_now;
      logic [7:0] cb;
      if (sel && wr && fifo_count(cyc) < DEPTH) begin
        s = cyc + 2;
        if (fr_start.size() > 0 && fr_start[$] + FRAME + 1 > s) s = fr_start[$] + FRAME + 1;
        fr_push.push_back(cyc); fr_start.push_back(s); fr_byte.push_back(wdata[7:0]);
      end
      commit = 1'b0; cb = '0;
      if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
        commit = 1'b1;
        cb = pend_byte.pop_front();
        void'(pend_cyc.pop_front());
      end
      rd_now = sel && rd;
      if (commit) begin
        if (m_vld && !rd_now) m_ovr = 1'b1;
        m_byte = cb;
        m_vld  = 1'b1;
      end
      if (rd_now) begin
        m_ovr = 1'b0;
        if (!commit) m_vld = 1'b0;
      end
    end
  end

  int          n_tests = 0, n_fail = 0;
  bit          chk_en = 0, done = 0;
  int          lq_cyc[$];
  bit          lq_tx[$];
  logic [31:0] lq_mask[$], lq_val[$];
  string       lq_name[$];

  task automatic expect_at(input int c, input bit is_tx, input logic [31:0] mask,
                           input logic [31:0] val, input string nm);
    lq_cyc.push_back(c); lq_tx.push_back(is_tx); lq_mask.push_back(mask);
    lq_val.push_back(val); lq_name.push_back(nm);
  endtask

  always @(negedge clk) begin : compare
    logic [31:0] act, exp_w;
    if (!rst && chk_en) begin
      n_tests++;
      if (tx !== tx_at(cyc)) begin
        n_fail++;
        $display("FAIL tx_model cycle %0d: got %b want %b", cyc, tx, tx_at(cyc));
      end
      exp_w = rdata_at(cyc);
      n_tests++;
      if (rdata !== exp_w) begin
        n_fail++;
        $display("FAIL rdata_model cycle %0d: got %h want %h", cyc, rdata, exp_w);
      end
    end
    while (lq_cyc.size() > 0 && lq_cyc[0] <= cyc) begin
      act = lq_tx[0] ? {31'b0, tx} : rdata;
      n_tests++;
      if (lq_cyc[0] != cyc || (act & lq_mask[0]) !== lq_val[0]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h (mask %h)", lq_name[0], cyc,
                 act & lq_mask[0], lq_val[0], lq_mask[0]);
      end
      void'(lq_cyc.pop_front()); void'(lq_tx.pop_front()); void'(lq_mask.pop_front());
      void'(lq_val.pop_front()); void'(lq_name.pop_front());
    end
    if (cyc > 3000 && !done) begin
      n_fail++;
      $display("FAIL timeout at cycle %0d", cyc);
      done = 1;
    end
    if (done) begin
      foreach (lq_name[i]) begin
        n_tests++; n_fail++;
        $display("FAIL %s never reached (cycle %0d)", lq_name[i], lq_cyc[i]);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic store(input logic [7:0] b);
    sel = 1'b1; wr = 1'b1; wdata = {24'hC0FFEE, b};
    step();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic load(input logic [31:0] exp_pre, input string nm);
    sel = 1'b1; rd = 1'b1;
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, exp_pre, nm);
    step();
    sel = 1'b0; rd = 1'b0;
  endtask

  // Commit lands mid stop bit as seen after the two synchroniser flops.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (stop) begin
      pend_cyc.push_back(cyc + 2 + 9 * CPB + CPB / 2);
      pend_byte.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      idle(CPB);
    end
    rx = 1'b1;
  endtask

  initial begin : stim
    int c;
    #2 rst = 1'b1;
    expect_at(1, 1'b0, 32'hFFFF_FFFF, 32'h0, "reset_rdata");
    expect_at(1, 1'b1, 32'h1, 32'h1, "reset_tx");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    idle(2);

    // Single byte 0xA5: start, LSB-first data, stop, busy drop.
    c = cyc;
    expect_at(c + 1,  1'b1, 32'h1, 32'h1, "t1_pop_cycle_idle");
    expect_at(c + 1,  1'b0, 32'h800, 32'h800, "t1_busy_fifo");
    expect_at(c + 2,  1'b1, 32'h1, 32'h0, "t1_start_bit");
    expect_at(c + 6,  1'b1, 32'h1, 32'h1, "t1_data_bit0");
    expect_at(c + 10, 1'b1, 32'h1, 32'h0, "t1_data_bit1");
    expect_at(c + 41, 1'b1, 32'h1, 32'h1, "t1_stop_bit");
    expect_at(c + 41, 1'b0, 32'h800, 32'h800, "t1_busy_in_stop");
    expect_at(c + 42, 1'b0, 32'hFFFF_FFFF, 32'h0, "t1_busy_drop");
    store(8'hA5);
    wait_until(c + 45);

    // 0xFF occupies the transmitter, 0x01..0x04 fill the FIFO, 0x05 is dropped.
    c = cyc;
    expect_at(c + 4,   1'b0, 32'h100, 32'h000, "t2_not_full");
    expect_at(c + 5,   1'b0, 32'h100, 32'h100, "t2_full");
    expect_at(c + 42,  1'b1, 32'h1, 32'h1, "t2_gap_idle");
    expect_at(c + 43,  1'b1, 32'h1, 32'h0, "t2_next_start");
    expect_at(c + 205, 1'b0, 32'h800, 32'h800, "t2_busy_last_stop");
    expect_at(c + 206, 1'b0, 32'hFFFF_FFFF, 32'h0, "t2_drained");
    store(8'hFF);
    for (int i = 1; i <= 5; i++) store(8'(i));
    wait_until(c + 210);

    // Receive 0x3C, then a load clears rx_valid.
    send_rx(8'h3C, 1'b1);
    idle(1);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h23C, "t3_rx_valid");
    load(32'h23C, "t3_load_data");
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h03C, "t3_cleared");
    idle(2);

    // Two frames without a load: overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    idle(1);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h622, "t4_overrun");
    load(32'h622, "t4_load_data");
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h022, "t4_cleared");
    idle(2);

    // Load in the exact commit cycle of 0x77 while 0x55 is still pending.
    send_rx(8'h55, 1'b1);
    idle(1);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h255, "t5_first");
    send_rx(8'h77, 1'b1);
    load(32'h255, "t5_load_pre_clear");
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h277, "t5_commit_with_read");
    idle(2);

    // One-cycle start glitch and a framing error leave the flags alone.
    rx = 1'b0;
    step();
    rx = 1'b1;
    idle(8);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h277, "t6_glitch");
    send_rx(8'hAA, 1'b0);
    idle(4);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h277, "t6_framing_error");
    send_rx(8'h5A, 1'b1);
    idle(1);
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h65A, "t6_recovers");
    idle(2);

    // Reset in the middle of a DATA bit.
    c = cyc;
    expect_at(c + 7, 1'b1, 32'h1, 32'h0, "t7_data_low");
    store(8'h00);
    wait_until(c + 8);
    #2;
    expect_at(cyc, 1'b1, 32'h1, 32'h1, "t7_async_tx");
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h0, "t7_async_rdata");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_at(cyc, 1'b0, 32'hFFFF_FFFF, 32'h0, "t7_after_release");
    // Store without select must not reach the FIFO.
    wr = 1'b1; wdata = 32'h0;
    step();
    wr = 1'b0;
    idle(50);
    done = 1;
  end

endmodule
